// File: rtl/rst_seq_pkg.sv
// Shared types and default constants for the reset-release sequencer.
package rst_seq_pkg;

  // Default parameter values for rst_release_seq.
  localparam int DEF_NUM_DOMAINS = 3;
  localparam int DEF_RELEASE_DLY = 4;
  localparam int DEF_ACK_TIMEOUT = 64;

  // Width of the shared delay/timeout counter and of the domain index.
  localparam int CNT_W = 8;
  localparam int IDX_W = 3;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLK_ON  = 3'd1,
    RELEASE = 3'd2,
    DONE    = 3'd3,
    SHUT    = 3'd4,
    OFF     = 3'd5
  } seq_state_e;

endpackage

// File: rtl/dly_cnt.sv
// Loadable 8-bit down-counter that saturates at zero. A single instance
// times both the clock-to-reset delays and the acknowledge timeouts.
module dly_cnt
  import rst_seq_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  // Load wins over counting; the counter parks at zero once it gets there.
  always_ff @(posedge CLK) begin
    if (RST) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - CNT_W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/rst_release_seq.sv
// Power-up / power-down sequencer for NUM_DOMAINS clock/reset domains.
// Power-up walks domains 0..N-1: clock enable first, reset release
// RELEASE_DLY cycles later, then waits for the domain acknowledge (bounded
// by ACK_TIMEOUT). Power-down walks N-1..0: reset first, clock enable off
// RELEASE_DLY cycles later.
//
// Handshake: DOMAIN_ACK is a synchronous level, sampled only while the
// sequencer waits in RELEASE for the current domain; there is no ready
// back-pressure, a domain simply holds its acknowledge high once up.
module rst_release_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
  parameter int RELEASE_DLY = DEF_RELEASE_DLY,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SHDN_REQ,
  input  logic [NUM_DOMAINS-1:0] DOMAIN_ACK,
  output logic [NUM_DOMAINS-1:0] CLK_EN,
  output logic [NUM_DOMAINS-1:0] DOMAIN_RST_N,
  output logic                   SEQ_DONE,
  output logic [NUM_DOMAINS-1:0] TIMEOUT_ERR
);

  localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(RELEASE_DLY - 1);
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAINS - 1);

  seq_state_e             state, nxt_state;
  logic [IDX_W-1:0]       idx, nxt_idx;
  logic [NUM_DOMAINS-1:0] clk_en_q, nxt_clk_en;
  logic [NUM_DOMAINS-1:0] rst_n_q, nxt_rst_n;
  logic                   done_q, nxt_done;
  logic [NUM_DOMAINS-1:0] terr_q, nxt_terr;

  logic [NUM_DOMAINS-1:0] cur_mask;
  logic                   ack_sel;
  logic                   cnt_load;
  logic [CNT_W-1:0]       cnt_load_val;
  logic [CNT_W-1:0]       cnt_value;
  logic                   cnt_zero;

  dly_cnt u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .value    (cnt_value),
    .zero     (cnt_zero)
  );

  // One-hot of the domain currently being sequenced, and its acknowledge.
  assign cur_mask = NUM_DOMAINS'(1) << idx;
  assign ack_sel  = |(DOMAIN_ACK & cur_mask);

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    nxt_state    = state;
    nxt_idx      = idx;
    nxt_clk_en   = clk_en_q;
    nxt_rst_n    = rst_n_q;
    nxt_done     = done_q;
    nxt_terr     = terr_q;
    cnt_load     = 1'b0;
    cnt_load_val = DLY_LOAD;

    case (state)
      IDLE, OFF: begin
        if (!SHDN_REQ) begin
          // Start power-up at domain 0: clock on now, reset after the delay.
          nxt_state  = CLK_ON;
          nxt_idx    = '0;
          nxt_clk_en = NUM_DOMAINS'(1);
          nxt_rst_n  = '0;
          nxt_done   = 1'b0;
          cnt_load   = 1'b1;
        end else if (state == IDLE) begin
          nxt_state = OFF;
        end
      end

      CLK_ON, RELEASE, DONE: begin
        if (SHDN_REQ) begin
          // Abort or begin power-down at the current domain; reset goes first.
          nxt_state = SHUT;
          nxt_rst_n = rst_n_q & ~cur_mask;
          nxt_done  = 1'b0;
          cnt_load  = 1'b1;
        end else if (state == CLK_ON) begin
          if (cnt_zero) begin
            nxt_state    = RELEASE;
            nxt_rst_n    = rst_n_q | cur_mask;
            cnt_load     = 1'b1;
            cnt_load_val = TO_LOAD;
          end
        end else if (state == RELEASE) begin
          if (ack_sel || cnt_zero) begin
            // A missing acknowledge is flagged but never stalls the sequence.
            if (!ack_sel) begin
              nxt_terr = terr_q | cur_mask;
            end
            if (idx == LAST_IDX) begin
              nxt_state = DONE;
              nxt_done  = 1'b1;
            end else begin
              nxt_state  = CLK_ON;
              nxt_idx    = idx + IDX_W'(1);
              nxt_clk_en = clk_en_q | (cur_mask << 1);
              cnt_load   = 1'b1;
            end
          end
        end
      end

      SHUT: begin
        // SHDN_REQ is deliberately ignored here until OFF is reached.
        if (cnt_zero) begin
          nxt_clk_en = clk_en_q & ~cur_mask;
          if (idx == '0) begin
            nxt_state = OFF;
          end else begin
            nxt_idx   = idx - IDX_W'(1);
            nxt_rst_n = rst_n_q & ~(cur_mask >> 1);
            cnt_load  = 1'b1;
          end
        end
      end

      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

  // State, index and output registers; RST drops everything with no ordering.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      idx      <= '0;
      clk_en_q <= '0;
      rst_n_q  <= '0;
      done_q   <= 1'b0;
      terr_q   <= '0;
    end else begin
      state    <= nxt_state;
      idx      <= nxt_idx;
      clk_en_q <= nxt_clk_en;
      rst_n_q  <= nxt_rst_n;
      done_q   <= nxt_done;
      terr_q   <= nxt_terr;
    end
  end

  // The counter's zero flag must always agree with its value.
  a_cnt_zero: assert property (@(posedge CLK) cnt_zero == (cnt_value == '0));

  assign CLK_EN       = clk_en_q;
  assign DOMAIN_RST_N = rst_n_q;
  assign SEQ_DONE     = done_q;
  assign TIMEOUT_ERR  = terr_q;

endmodule
